ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  Receives PS/2 keyboard frames from the keyboard_data/keyboard_clock pins and queues the 8-bit scan codes.
//  Sits between the board pins and the CPU keyboard/MMIO logic; all logic runs in the CLK_CPU domain.
//  Checks the start, parity and stop bits and recovers from stuck or partial frames with a timeout.
// PARAMETERS
//  FIFO_DEPTH      8      scan-code queue entries; must be a power of 2, >=2
//  FILTER_LEN      4      CLK_CPU cycles a synchronized PS/2 clock level must be stable before it is accepted
//  TIMEOUT_CYCLES  16000  max CLK_CPU cycles between PS/2 clock falling edges inside a frame (1 ms @16 MHz)
// PORTS
//  CLK_CPU         in   1  system clock; every flop here uses it
//  resetn          in   1  asynchronous, active-low reset
//  keyboard_clock  in   1  raw PS/2 clock pin, asynchronous to CLK_CPU
//  keyboard_data   in   1  raw PS/2 data pin, asynchronous to CLK_CPU
//  code_data       out  8  scan code at the FIFO head; valid only while code_valid=1
//  code_valid      out  1  FIFO not empty
//  code_ready      in   1  consumer pops the head on a cycle where code_valid&code_ready=1
//  parity_err      out  1  one-cycle pulse: frame dropped because of bad odd parity
//  frame_err       out  1  one-cycle pulse: frame dropped because start=1, stop=0 or a timeout fired
//  overflow        out  1  sticky: a good frame arrived while the FIFO was full
//  clr_overflow    in   1  clears overflow; a new overflow in the same cycle wins
//  busy            out  1  FSM is not in IDLE
// BEHAVIOUR
//  Reset: FIFO empty, code_valid=0, code_data=0, parity_err=0, frame_err=0, overflow=0, busy=0, FSM=IDLE,
//   filtered clock level=1, synchronizers=1.
//  Input path: each pin goes through a 2-FF synchronizer. The clock filter counter resets on any change of
//   the synced clock. The filtered level changes only after FILTER_LEN stable cycles.
//  Sample strobe: a 1->0 transition of the filtered clock. Data is sampled on the strobe from the synced data.
//   Strobe latency from the pin edge is 2+FILTER_LEN cycles.
//  FSM states: IDLE, DATA, PARITY, STOP.
//   IDLE:   strobe with data=0 -> DATA, bit_cnt=0. Strobe with data=1 -> pulse frame_err, stay in IDLE.
//   DATA:   each strobe shifts the data bit into shreg LSB-first and increments bit_cnt; after 8 bits -> PARITY.
//   PARITY: strobe captures p -> STOP.
//   STOP:   strobe -> IDLE. If stop=0, pulse frame_err. Else if ^{shreg,p}=0, pulse parity_err.
//           Else the code is good: push it, or set overflow if the FIFO is full.
//  Timeout: in any state except IDLE, a counter counts cycles since the last strobe.
//   At TIMEOUT_CYCLES it forces IDLE, pulses frame_err and discards the partial byte.
//  Error and overflow pulses are registered and assert the cycle after the deciding strobe.
//  A pushed code is visible on code_valid/code_data one cycle after the STOP strobe.
//  FIFO: first-word-fall-through. code_data is the head.
//   Push and pop in the same cycle are allowed when the FIFO is full or non-empty; count stays unchanged.
//   A push to a full FIFO is dropped and the existing contents are preserved.
//   Pointers have log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//   full = MSBs differ and lower bits equal; empty = pointers equal.
//  Reset deasserted mid-frame: the FSM restarts in IDLE. The partial frame is lost and no error is reported.
//   The bits that follow the reset may be reported as a frame_err.
//  The host-to-device (inhibit/transmit) direction is out of scope; this block never drives the pins.
// STRUCTURE
//  ps2_pkg: ps2_state_e enum {IDLE,DATA,PARITY,STOP}; PS2_DATA_BITS=8;
//   helper function odd_parity_ok(byte,p).
//  Sub-module ps2_rx_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH): generic FWFT FIFO with push/full/pop/empty.
//   Its reset is also async active-low.
//  The synchronizers, clock filter, FSM and timeout counter stay in ps2_keyboard_rx.
// TESTING (PS/2 bit period 100 us, 50 us half-periods; CLK_CPU 16 MHz unless stated)
//  1. Send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) with code_ready=1
//     -> one code_valid beat with code_data=0x1C; no error pulses.
//  2. Send 0xF0 then 0x1C with code_ready=0, then pop both
//     -> code_data=0xF0 then 0x1C, in order; code_valid=0 afterwards.
//  3. Send 0x1C with the parity bit inverted -> exactly one parity_err pulse; FIFO stays empty.
//  4. Send 9 good frames 0x01..0x09 with code_ready=0
//     -> FIFO holds 0x01..0x08, overflow=1; clr_overflow=1 for one cycle -> overflow=0.
//  5. Stop the PS/2 clock after 4 data bits -> frame_err pulse TIMEOUT_CYCLES cycles after the last edge.
//     A following good frame 0x5A is received correctly.
//  6. Inject 1-cycle glitches on keyboard_clock in the middle of a frame -> no extra bits are shifted.
//     Then assert resetn=0 mid-frame -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, constants and parity helper for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic p);
    return ^{data_byte, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through FIFO; the head entry is always presented on dout.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage next-state; a push into a full FIFO only lands if the head leaves this cycle.
  always_comb begin
    mem_d     = mem_q;
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers; storage clears so the empty head reads as zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronizers, clock deglitch filter, frame FSM with timeout, scan-code FIFO.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic       CLK_CPU,
  input  logic       resetn,
  input  logic       keyboard_clock,
  input  logic       keyboard_data,
  output logic [7:0] code_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  logic [1:0]       kclk_sync_q, kclk_sync_d;
  logic [1:0]       kdat_sync_q, kdat_sync_d;
  logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
  logic             filt_lvl_q, filt_lvl_d;
  ps2_state_e       state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             overflow_q, overflow_d;
  logic             clk_changed_s, strobe_s, data_s, timeout_s;
  logic             push_s, pop_s, fifo_full_s, fifo_empty_s;

  // Two-stage synchronizers; stage [1] is the usable synchronized level.
  always_comb begin
    kclk_sync_d = {kclk_sync_q[0], keyboard_clock};
    kdat_sync_d = {kdat_sync_q[0], keyboard_data};
  end

  assign clk_changed_s = kclk_sync_q[1] ^ kclk_sync_q[0];
  assign data_s        = kdat_sync_q[1];

  // Clock filter: the level is accepted only once it has held steady for FILTER_LEN cycles.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    filt_lvl_d = filt_lvl_q;
    if (clk_changed_s) begin
      filt_cnt_d = '0;
    end else begin
      if (filt_cnt_q != FCW'(FILTER_LEN)) begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end else begin
        filt_cnt_d = filt_cnt_q;
      end
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_lvl_d = kclk_sync_q[1];
      end else begin
        filt_lvl_d = filt_lvl_q;
      end
    end
  end

  assign strobe_s = filt_lvl_q & ~filt_lvl_d;

  // Frame FSM with inter-edge timeout; also decides error pulses and FIFO pushes.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_s       = 1'b0;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (strobe_s) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TCW'(1);
    end
    timeout_s = (state_q != IDLE) && !strobe_s && (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));
    case (state_q)
      IDLE: begin
        if (strobe_s) begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (strobe_s) begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (strobe_s) begin
          par_d   = data_s;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (strobe_s) begin
          state_d = IDLE;
          if (!data_s) begin
            frame_err_d = 1'b1;
          end else if (!odd_parity_ok(shreg_q, par_q)) begin
            parity_err_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (timeout_s) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      bit_cnt_d   = '0;
      shreg_d     = 8'h00;
    end else begin
      state_d = state_d;
    end
  end

  assign pop_s = ~fifo_empty_s & code_ready;

  // Sticky overflow: a good code that cannot be stored sets it; a new overflow beats a clear.
  always_comb begin
    overflow_d = overflow_q;
    if (push_s && fifo_full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // All receiver state registers.
  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      kclk_sync_q  <= 2'b11;
      kdat_sync_q  <= 2'b11;
      filt_cnt_q   <= '0;
      filt_lvl_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      kclk_sync_q  <= kclk_sync_d;
      kdat_sync_q  <= kdat_sync_d;
      filt_cnt_q   <= filt_cnt_d;
      filt_lvl_q   <= filt_lvl_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  ps2_rx_fifo #(
    .WIDTH(PS2_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_CPU),
    .resetn(resetn),
    .push  (push_s),
    .din   (shreg_q),
    .full  (fifo_full_s),
    .pop   (pop_s),
    .dout  (code_data),
    .empty (fifo_empty_s)
  );

  assign code_valid = ~fifo_empty_s;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, decoupled output monitor.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int TO   = 1000;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       resetn;
  logic       kb_clk, kb_data;
  logic [7:0] code_data;
  logic       code_valid, code_ready;
  logic       parity_err, frame_err, overflow, clr_overflow, busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fe_seen = 0;
  int         pe_seen = 0;
  int         fe_last_cyc = 0;
  int         last_fall = 0;
  logic [7:0] exp_q[$];

  ps2_keyboard_rx #(
    .FIFO_DEPTH(8),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_CPU       (clk),
    .resetn        (resetn),
    .keyboard_clock(kb_clk),
    .keyboard_data (kb_data),
    .code_data     (code_data),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow),
    .busy          (busy)
  );

  always #31.25 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted code and counts error pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (resetn === 1'b1) begin
        if (frame_err === 1'b1) begin
          fe_seen++;
          fe_last_cyc = cyc;
        end
        if (parity_err === 1'b1) pe_seen++;
        if (code_valid === 1'b1 && code_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_code", {24'h0, code_data}, 32'hFFFF_FFFF);
          end else begin
            check("code_data", {24'h0, code_data}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first n bits of an 11-bit frame; optional 1-cycle clock glitches mid-frame.
  task automatic send_raw(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      kb_data = f[i];
      if (glitch && (i == 3 || i == 6)) begin
        wait_cyc(HALF / 2);
        kb_clk = 1'b0;
        wait_cyc(1);
        kb_clk = 1'b1;
        wait_cyc(HALF - HALF / 2 - 1);
      end else begin
        wait_cyc(HALF);
      end
      kb_clk    = 1'b0;
      last_fall = cyc;
      if (glitch && (i == 3 || i == 6)) begin
        wait_cyc(HALF / 2);
        kb_clk = 1'b1;
        wait_cyc(1);
        kb_clk = 1'b0;
        wait_cyc(HALF - HALF / 2 - 1);
      end else begin
        wait_cyc(HALF);
      end
      kb_clk = 1'b1;
    end
    wait_cyc(HALF);
    kb_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_raw(f, 11, glitch);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) wait_cyc(1);
    wait_cyc(3);
    check(name, exp_q.size(), 0);
    check({name, "_valid"}, {31'h0, code_valid}, 0);
  endtask

  initial begin
    int fe0;
    int diff;
    resetn = 1'b0; kb_clk = 1'b1; kb_data = 1'b1;
    code_ready = 1'b0; clr_overflow = 1'b0;
    wait_cyc(5);
    #1;
    check("rst_valid", {31'h0, code_valid}, 0);
    check("rst_data", {24'h0, code_data}, 0);
    check("rst_errs", {29'h0, parity_err, frame_err, overflow}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    wait_cyc(1);
    resetn = 1'b1;
    wait_cyc(20);

    // 1: single frame 0x1C, consumer ready
    code_ready = 1'b1;
    exp_q.push_back(8'h1C);
    send_byte(8'h1C, 1'b0, 1'b0);
    wait_drain("t1_drain");
    check("t1_no_fe", fe_seen, 0);
    check("t1_no_pe", pe_seen, 0);

    // 2: two frames queued, then popped in order
    code_ready = 1'b0;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h1C);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);
    check("t2_valid", {31'h0, code_valid}, 1);
    check("t2_head", {24'h0, code_data}, 32'hF0);
    code_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: bad parity
    send_byte(8'h1C, 1'b1, 1'b0);
    wait_cyc(10);
    check("t3_pe", pe_seen, 1);
    check("t3_fe", fe_seen, 0);
    check("t3_empty", {31'h0, code_valid}, 0);

    // 4: nine frames into an 8-deep FIFO
    code_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) exp_q.push_back(8'(k));
      send_byte(8'(k), 1'b0, 1'b0);
    end
    check("t4_overflow", {31'h0, overflow}, 1);
    check("t4_head", {24'h0, code_data}, 32'h01);
    clr_overflow = 1'b1;
    wait_cyc(1);
    clr_overflow = 1'b0;
    #1;
    check("t4_clr", {31'h0, overflow}, 0);
    code_ready = 1'b1;
    wait_drain("t4_drain");

    // 5: stalled frame times out, then a good frame
    fe0 = fe_seen;
    send_raw({1'b1, 1'b0, 8'h5A, 1'b0}, 5, 1'b0);
    check("t5_busy", {31'h0, busy}, 1);
    for (int i = 0; i < TO + 200 && fe_seen == fe0; i++) wait_cyc(1);
    check("t5_fe", fe_seen, fe0 + 1);
    diff = fe_last_cyc - last_fall;
    check("t5_latency_ok", {31'h0, (diff >= TO && diff <= TO + 12)}, 1);
    check("t5_idle", {31'h0, busy}, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0, 1'b0);
    wait_drain("t5_drain");

    // 6: glitchy clock, then reset mid-frame
    exp_q.push_back(8'hA7);
    send_byte(8'hA7, 1'b0, 1'b1);
    wait_drain("t6_drain");
    code_ready = 1'b0;
    send_byte(8'h33, 1'b0, 1'b0);
    check("t6_held", {23'h0, code_valid, code_data}, 32'h133);
    send_raw({1'b1, 1'b0, 8'h66, 1'b0}, 4, 1'b0);
    check("t6_busy", {31'h0, busy}, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("t6_rst_out", {20'h0, code_data, code_valid, parity_err, frame_err, overflow},
          32'h0);
    check("t6_rst_busy", {31'h0, busy}, 0);
    wait_cyc(5);
    resetn = 1'b1;
    wait_cyc(20);
    code_ready = 1'b1;
    exp_q.push_back(8'h29);
    send_byte(8'h29, 1'b0, 1'b0);
    wait_drain("t6_after");
    check("final_fe", fe_seen, 1);
    check("final_pe", pe_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
